hp_fifo: RTL and testbench

Parametrised host-to-parasite FIFO, successor to the single-byte buffer.
- Host writes on falling h_phi2; the parasite reads in its own p_phi2 domain.
- Pointers cross clock domains as Gray code through synchronisers.
- Runtime mode selects single-entry behaviour (legacy register) or full-depth behaviour (Tube R3 two-byte style).
- Instanced per register channel in the Tube top level.

---
 rtl/hp_fifo_pkg.sv | 52 +++++
 rtl/hp_fifo_gray_sync.sv | 60 ++++++
 rtl/hp_fifo.sv | 240 ++++++++++++++++++++++++
 tb/tb_hp_fifo.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hp_fifo_pkg.sv
// -----------------------------------------------------------------------------
// hp_fifo_pkg
//
// Shared definitions for the host-to-parasite FIFO and its pointer
// synchronisers. It provides:
//   - the default sizing parameters of a Tube register channel;
//   - the edge-select type used by tube_gray_sync;
//   - the log2 helper and the Gray encode/decode functions.
//
// The Gray helpers work on a fixed-width word. Callers zero-extend their
// pointer into a gray_word_t and truncate the result back to pointer width.
// The upper bits stay zero through both conversions, so the truncation loses
// nothing.
// -----------------------------------------------------------------------------
package hp_fifo_pkg;

  localparam int unsigned HP_FIFO_DEF_WIDTH = 8;
  localparam int unsigned HP_FIFO_DEF_DEPTH = 2;
  localparam int unsigned HP_FIFO_DEF_SYNC  = 2;

  // Widest pointer the Gray helpers can carry.
  localparam int unsigned GRAY_MAX_W = 32;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  // Clock edge on which a synchroniser chain samples.
  typedef enum logic {
    EDGE_RISE = 1'b0,
    EDGE_FALL = 1'b1
  } sync_edge_e;

  // log2 of a power-of-two entry count. A value of 1 still yields one
  // address bit, so every pointer has an index field and a wrap bit.
  function automatic int unsigned tube_log2(input int unsigned value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  function automatic gray_word_t bin2gray(input gray_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of every Gray bit at or above it.
  function automatic gray_word_t gray2bin(input gray_word_t gray);
    gray_word_t bin;
    bin = gray;
    for (int i = 1; i < int'(GRAY_MAX_W); i++) begin
      bin = bin ^ (gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/hp_fifo_gray_sync.sv
// -----------------------------------------------------------------------------
// tube_gray_sync
//
// Multi-flop synchroniser that carries a Gray-coded pointer (or any
// quasi-static level) into a destination clock domain. Only one bit of a Gray
// pointer changes per increment, so a capture that lands mid-transition
// resolves to either the old value or the new value, never to a mix.
//
// Parameters:
//   WIDTH  - bits carried
//   STAGES - flop stages in the chain (at least 2)
//   EDGE   - EDGE_RISE or EDGE_FALL: the clock edge the chain samples on
//
// Ports:
//   clk_i   in   destination clock
//   rst_b_i in   asynchronous active-low reset; clears every stage
//   d_i     in   value from the source domain (must come from a flop)
//   q_o     out  synchronised value, valid in the destination domain
// -----------------------------------------------------------------------------
module tube_gray_sync
  import hp_fifo_pkg::*;
#(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2,
  parameter sync_edge_e  EDGE   = EDGE_RISE
) (
  input  logic             clk_i,
  input  logic             rst_b_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  if (EDGE == EDGE_FALL) begin : g_fall
    always_ff @(negedge clk_i or negedge rst_b_i) begin
      if (!rst_b_i) begin
        for (int i = 0; i < int'(STAGES); i++) stage_q[i] <= '0;
      end else begin
        // NOTE: state is updated with non-blocking assignments so every
        // stage samples its predecessor's old value; blocking assignments
        // would collapse the chain into a single flop.
        stage_q[0] <= d_i;
        for (int i = 1; i < int'(STAGES); i++) stage_q[i] <= stage_q[i-1];
      end
    end
  end else begin : g_rise
    always_ff @(posedge clk_i or negedge rst_b_i) begin
      if (!rst_b_i) begin
        for (int i = 0; i < int'(STAGES); i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < int'(STAGES); i++) stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/hp_fifo.sv
// -----------------------------------------------------------------------------
// hp_fifo
//
// Parametrised host-to-parasite FIFO for one Tube register channel. It
// replaces the single-byte buffer. The host pushes on the falling edge of
// h_phi2. The parasite pops on the rising edge of p_phi2 when p_phi2_en is
// high.
//
// Each pointer has log2(DEPTH)+1 bits. The extra MSB separates full from
// empty. Each pointer crosses into the other domain as Gray code through
// SYNC_STAGES flops. Both status flags are pessimistic: the host may see
// "full" late after a pop, and the parasite may see "available" late after
// a push. Neither error is unsafe.
//
// h_multi selects the mode at run time:
//   1 - full-depth mode: h_full asserts at DEPTH entries.
//   0 - single-entry mode (legacy register): h_full asserts at any occupancy.
// Entries already buffered when the mode changes are kept and drain normally.
//
// Optional build macro HP_FIFO_NMI_EN adds the output p_nmi, registered in
// the parasite domain:
//   - synced single-entry mode: p_nmi = p_data_available;
//   - synced full-depth mode:   p_nmi = FIFO full as seen by the parasite.
// Without the macro the port, the logic and the h_multi synchroniser are
// all absent.
//
// Parameters: WIDTH (data bits), DEPTH (power of two, >= 2),
//             SYNC_STAGES (>= 2).
//
// Ports:
//   h_phi2           in   host clock; host state updates on its falling edge
//   p_phi2           in   parasite clock; parasite state updates on rising edge
//   h_rst_b          in   asynchronous active-low reset for both domains
//   h_we_b           in   host write strobe, active low
//   h_selectData     in   host selects this channel's data register
//   h_data           in   host write data
//   h_multi          in   1 = full-depth mode, 0 = single-entry mode
//   p_phi2_en        in   parasite clock enable (gates pops only)
//   p_selectData     in   parasite selects this channel's data register
//   p_rdnw           in   parasite read (1) / write (0); writes are ignored
//   p_data           out  head-of-FIFO data, combinational from the memory
//   p_data_available out  at least one entry visible to the parasite
//   h_full           out  host may not write
//   h_overrun        out  sticky: a host write was dropped while full
//   p_nmi            out  (HP_FIFO_NMI_EN only) parasite interrupt request
// -----------------------------------------------------------------------------
module hp_fifo
  import hp_fifo_pkg::*;
#(
  parameter int unsigned WIDTH       = HP_FIFO_DEF_WIDTH,
  parameter int unsigned DEPTH       = HP_FIFO_DEF_DEPTH,
  parameter int unsigned SYNC_STAGES = HP_FIFO_DEF_SYNC
) (
  input  logic             h_phi2,
  input  logic             p_phi2,
  input  logic             h_rst_b,
  input  logic             h_we_b,
  input  logic             h_selectData,
  input  logic [WIDTH-1:0] h_data,
  input  logic             h_multi,
  input  logic             p_phi2_en,
  input  logic             p_selectData,
  input  logic             p_rdnw,
  output logic [WIDTH-1:0] p_data,
  output logic             p_data_available,
  output logic             h_full,
  output logic             h_overrun
`ifdef HP_FIFO_NMI_EN
  ,
  output logic             p_nmi
`endif
);

  // Address bits index the memory. The one extra pointer bit counts laps,
  // so pointers wrap modulo 2*DEPTH.
  localparam int unsigned AW = tube_log2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef logic [PW-1:0] ptr_t;

  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

  // ---------------------------------------------------------------------------
  // Storage. Written in the host domain, read combinationally by the parasite.
  // An entry is never overwritten while the parasite can see it: the host
  // view of occupancy can only be too high, never too low.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Host domain (falling h_phi2)
  // ---------------------------------------------------------------------------
  ptr_t wptr_q, wptr_d;
  ptr_t wptr_gray_q;     // Gray copy kept in a flop so the crossing is glitch-free
  logic overrun_q, overrun_d;
  ptr_t rptr_gray_h;     // read pointer synchronised into the host domain
  ptr_t rptr_h;
  ptr_t h_count;
  logic push_req;
  logic push;

  assign rptr_h = ptr_t'(gray2bin(gray_word_t'(rptr_gray_h)));

  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    push_req  = 1'b0;
    push      = 1'b0;
    h_count   = '0;
    h_full    = 1'b0;
    wptr_d    = wptr_q;
    overrun_d = overrun_q;

    push_req = h_selectData & ~h_we_b;
    h_count  = wptr_q - rptr_h;      // wraps modulo 2*DEPTH by pointer width

    if (h_multi) h_full = (h_count == DEPTH_P);
    else         h_full = (h_count != '0);

    push = push_req & ~h_full;
    if (push)              wptr_d    = wptr_q + ptr_t'(1);
    if (push_req & h_full) overrun_d = 1'b1;
  end

  always_ff @(negedge h_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      wptr_q      <= '0;
      wptr_gray_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      wptr_gray_q <= ptr_t'(bin2gray(gray_word_t'(wptr_d)));
      overrun_q   <= overrun_d;
    end
  end

  // NOTE: the memory is reset on purpose. p_data reads it combinationally,
  // and after reset it must show zero, not whatever the previous transfer
  // left behind.
  always_ff @(negedge h_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wptr_q[AW-1:0]] <= h_data;
    end
  end

  assign h_overrun = overrun_q;

  // ---------------------------------------------------------------------------
  // Parasite domain (rising p_phi2). The synchronisers run freely; only the
  // pop is qualified by p_phi2_en.
  // ---------------------------------------------------------------------------
  ptr_t rptr_q, rptr_d;
  ptr_t rptr_gray_q;
  ptr_t wptr_gray_p;     // write pointer synchronised into the parasite domain
  ptr_t wptr_p;
  logic avail;
  logic pop;

  assign wptr_p = ptr_t'(gray2bin(gray_word_t'(wptr_gray_p)));

  always_comb begin
    avail  = (wptr_p != rptr_q);
    pop    = p_phi2_en & p_selectData & p_rdnw & avail;
    rptr_d = pop ? (rptr_q + ptr_t'(1)) : rptr_q;
  end

  always_ff @(posedge p_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      rptr_q      <= '0;
      rptr_gray_q <= '0;
    end else begin
      rptr_q      <= rptr_d;
      rptr_gray_q <= ptr_t'(bin2gray(gray_word_t'(rptr_d)));
    end
  end

  assign p_data_available = avail;
  assign p_data           = mem_q[rptr_q[AW-1:0]];

  // ---------------------------------------------------------------------------
  // Pointer crossings
  // ---------------------------------------------------------------------------
  tube_gray_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES),
    .EDGE   (EDGE_RISE)
  ) u_wptr_sync (
    .clk_i   (p_phi2),
    .rst_b_i (h_rst_b),
    .d_i     (wptr_gray_q),
    .q_o     (wptr_gray_p)
  );

  tube_gray_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES),
    .EDGE   (EDGE_FALL)
  ) u_rptr_sync (
    .clk_i   (h_phi2),
    .rst_b_i (h_rst_b),
    .d_i     (rptr_gray_q),
    .q_o     (rptr_gray_h)
  );

`ifdef HP_FIFO_NMI_EN
  // ---------------------------------------------------------------------------
  // Parasite interrupt. The mode bit is quasi-static, so a plain level
  // synchroniser is enough to carry it into the parasite domain.
  // ---------------------------------------------------------------------------
  logic multi_p;
  ptr_t p_fill;
  logic nmi_q, nmi_d;

  tube_gray_sync #(
    .WIDTH  (1),
    .STAGES (SYNC_STAGES),
    .EDGE   (EDGE_RISE)
  ) u_multi_sync (
    .clk_i   (p_phi2),
    .rst_b_i (h_rst_b),
    .d_i     (h_multi),
    .q_o     (multi_p)
  );

  always_comb begin
    p_fill = wptr_p - rptr_q;
    nmi_d  = multi_p ? (p_fill == DEPTH_P) : avail;
  end

  always_ff @(posedge p_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) nmi_q <= 1'b0;
    else          nmi_q <= nmi_d;
  end

  assign p_nmi = nmi_q;
`endif

endmodule

// File: tb/tb_hp_fifo.sv
// -----------------------------------------------------------------------------
// tb_hp_fifo
//
// Bench for hp_fifo. Two instances share all inputs:
//   dut2 - DEPTH=2
//   dut4 - DEPTH=4
// Each scenario task checks the instance it concerns.
//
// The host clock has a 10 ns period. The parasite clock has a 14.2 ns period.
// Their active edges never coincide, so every latency counted in edges is
// exact. Host stimulus changes on rising h_phi2, which is the inactive edge.
// Parasite stimulus and sampling happen on falling p_phi2.
//
// The streaming scenario compares the design against a queue model. Every
// accepted push goes into the queue, and every pop must return the queue
// head. Two flag bounds follow from the pointer arithmetic:
//   - h_full must be set whenever pushes - pops == DEPTH;
//   - p_data_available must be clear whenever pushes == pops.
// -----------------------------------------------------------------------------
`timescale 1ns/10ps
module tb_hp_fifo;

  localparam int SS = 2;

  logic       h_phi2  = 1'b1;
  logic       p_phi2  = 1'b0;
  logic       h_rst_b = 1'b0;
  logic       h_we_b  = 1'b1;
  logic       h_sel   = 1'b0;
  logic [7:0] h_data  = 8'h00;
  logic       h_multi = 1'b1;
  logic       p_en    = 1'b1;
  logic       p_sel   = 1'b0;
  logic       p_rdnw  = 1'b1;

  logic [7:0] p_data2, p_data4;
  logic       avail2, avail4, full2, full4, ovr2, ovr4;
`ifdef HP_FIFO_NMI_EN
  logic       nmi2, nmi4;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sb_q [$];
  int pushes;
  int pops;

  always #5   h_phi2 = ~h_phi2;
  always #7.1 p_phi2 = ~p_phi2;

  hp_fifo #(.WIDTH(8), .DEPTH(2), .SYNC_STAGES(SS)) dut2 (
    .h_phi2           (h_phi2),
    .p_phi2           (p_phi2),
    .h_rst_b          (h_rst_b),
    .h_we_b           (h_we_b),
    .h_selectData     (h_sel),
    .h_data           (h_data),
    .h_multi          (h_multi),
    .p_phi2_en        (p_en),
    .p_selectData     (p_sel),
    .p_rdnw           (p_rdnw),
    .p_data           (p_data2),
    .p_data_available (avail2),
    .h_full           (full2),
    .h_overrun        (ovr2)
`ifdef HP_FIFO_NMI_EN
    ,
    .p_nmi            (nmi2)
`endif
  );

  hp_fifo #(.WIDTH(8), .DEPTH(4), .SYNC_STAGES(SS)) dut4 (
    .h_phi2           (h_phi2),
    .p_phi2           (p_phi2),
    .h_rst_b          (h_rst_b),
    .h_we_b           (h_we_b),
    .h_selectData     (h_sel),
    .h_data           (h_data),
    .h_multi          (h_multi),
    .p_phi2_en        (p_en),
    .p_selectData     (p_sel),
    .p_rdnw           (p_rdnw),
    .p_data           (p_data4),
    .p_data_available (avail4),
    .h_full           (full4),
    .h_overrun        (ovr4)
`ifdef HP_FIFO_NMI_EN
    ,
    .p_nmi            (nmi4)
`endif
  );

  // Packed view of one instance's outputs: {p_data, available, full, overrun}.
  function automatic logic [10:0] outs_of(input int d);
    return (d == 2) ? {p_data2, avail2, full2, ovr2} : {p_data4, avail4, full4, ovr4};
  endfunction

  function automatic logic avail_of(input int d);
    return (d == 2) ? avail2 : avail4;
  endfunction

  task automatic host_write(input logic [7:0] v);
    @(posedge h_phi2);
    h_data = v; h_sel = 1'b1; h_we_b = 1'b0;
    @(posedge h_phi2);
    h_sel = 1'b0; h_we_b = 1'b1;
  endtask

  task automatic apply_reset();
    @(posedge h_phi2); #0.25;
    h_rst_b = 1'b0;
    h_sel = 1'b0; h_we_b = 1'b1; p_sel = 1'b0; p_rdnw = 1'b1; p_en = 1'b1;
    #3;
    @(posedge h_phi2); #0.25;
    h_rst_b = 1'b1;
    repeat (2) @(posedge h_phi2);
  endtask

  task automatic wait_avail(input int d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge p_phi2);
      if (avail_of(d)) begin ok = 1'b1; break; end
    end
  endtask

  // Call on a falling p_phi2 edge; one pop happens on the next rising edge.
  task automatic p_pop();
    p_en = 1'b1; p_rdnw = 1'b1; p_sel = 1'b1;
    @(posedge p_phi2); #1;
    p_sel = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #2;
    for (int d = 2; d <= 4; d += 2) begin
      n_checks++;
      if (outs_of(d) !== 11'h000) begin
        n_fail++;
        $display("FAIL reset_held_dut%0d: outputs=%h expected 000", d, outs_of(d));
      end
    end
    @(posedge h_phi2); #0.25;
    h_rst_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge h_phi2);
      for (int d = 2; d <= 4; d += 2) begin
        n_checks++;
        if (outs_of(d) !== 11'h000) begin
          n_fail++;
          $display("FAIL reset_idle_dut%0d: outputs=%h expected 000 (cycle %0d)", d, outs_of(d), i);
        end
      end
`ifdef HP_FIFO_NMI_EN
      n_checks++;
      if ({nmi2, nmi4} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_idle_nmi: p_nmi=%b%b expected 00", nmi2, nmi4);
      end
`endif
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_multi();
    int lat;
    int n;
    bit found;
    apply_reset();
    h_multi = 1'b1;
    @(posedge h_phi2);
    h_data = 8'h11; h_sel = 1'b1; h_we_b = 1'b0;
    @(negedge h_phi2);
    lat = 0; found = 1'b0;
    fork
      begin
        @(posedge h_phi2);
        n_checks++;
        if (full2 !== 1'b0) begin
          n_fail++; $display("FAIL multi_full_after_one: h_full=%b expected 0", full2);
        end
        h_data = 8'h22;
        @(posedge h_phi2);
        h_sel = 1'b0; h_we_b = 1'b1;
        n_checks++;
        if (full2 !== 1'b1) begin
          n_fail++; $display("FAIL multi_full_after_two: h_full=%b expected 1", full2);
        end
      end
      begin
        for (int i = 0; i < 10 && !found; i++) begin
          @(posedge p_phi2); lat++;
          @(negedge p_phi2);
          if (avail2) found = 1'b1;
        end
      end
    join
    n_checks++;
    if (!found || lat != SS) begin
      n_fail++; $display("FAIL multi_avail_latency: edges=%0d found=%b expected %0d", lat, found, SS);
    end
    n_checks++;
    if (p_data2 !== 8'h11) begin
      n_fail++; $display("FAIL multi_head_first: p_data=%h expected 11", p_data2);
    end
    repeat (4) @(negedge p_phi2);
    n_checks++;
    if ({avail2, p_data2} !== {1'b1, 8'h11}) begin
      n_fail++; $display("FAIL multi_read1: avail,data=%b,%h expected 1,11", avail2, p_data2);
    end
    // First pop, then count falling h_phi2 edges until h_full drops.
    p_en = 1'b1; p_rdnw = 1'b1; p_sel = 1'b1;
    n = 0; found = 1'b0;
    fork
      begin @(posedge p_phi2); #1; p_sel = 1'b0; end
      begin
        @(posedge p_phi2);
        for (int i = 0; i < 10 && !found; i++) begin
          @(negedge h_phi2); n++;
          @(posedge h_phi2);
          if (!full2) found = 1'b1;
        end
      end
    join
    n_checks++;
    if (!found || n != SS) begin
      n_fail++; $display("FAIL multi_full_release: edges=%0d found=%b expected %0d", n, found, SS);
    end
    @(negedge p_phi2);
    n_checks++;
    if ({avail2, p_data2} !== {1'b1, 8'h22}) begin
      n_fail++; $display("FAIL multi_read2: avail,data=%b,%h expected 1,22", avail2, p_data2);
    end
    p_pop();
    @(negedge p_phi2);
    n_checks++;
    if (avail2 !== 1'b0) begin
      n_fail++; $display("FAIL multi_drained: avail=%b expected 0", avail2);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single();
    bit ok;
    apply_reset();
    h_multi = 1'b0;
    host_write(8'hA5);
    n_checks++;
    if ({full2, ovr2} !== 2'b10) begin
      n_fail++; $display("FAIL single_full: full,ovr=%b%b expected 10", full2, ovr2);
    end
    host_write(8'h5A);
    n_checks++;
    if ({full2, ovr2} !== 2'b11) begin
      n_fail++; $display("FAIL single_overrun: full,ovr=%b%b expected 11", full2, ovr2);
    end
    wait_avail(2, ok);
    n_checks++;
    if (!ok || p_data2 !== 8'hA5) begin
      n_fail++; $display("FAIL single_read: seen=%b data=%h expected 1,a5", ok, p_data2);
    end
    p_pop();
    @(negedge p_phi2);
    n_checks++;
    if ({avail2, p_data2} !== {1'b0, 8'h00}) begin
      n_fail++; $display("FAIL single_dropped: avail,data=%b,%h expected 0,00", avail2, p_data2);
    end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge h_phi2);
      if (!full2) ok = 1'b1;
    end
    n_checks++;
    if (!ok || ovr2 !== 1'b1) begin
      n_fail++; $display("FAIL single_sticky: full_cleared=%b ovr=%b expected 1,1", ok, ovr2);
    end
    h_multi = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_mode_change();
    bit ok;
    apply_reset();
    h_multi = 1'b1;
    host_write(8'h31);
    host_write(8'h32);
    h_multi = 1'b0;
    wait_avail(2, ok);
    p_pop();
    repeat (8) @(posedge h_phi2);
    n_checks++;
    if (full2 !== 1'b1) begin
      n_fail++; $display("FAIL mode_full_one_left: h_full=%b expected 1", full2);
    end
    @(negedge p_phi2);
    n_checks++;
    if ({avail2, p_data2} !== {1'b1, 8'h32}) begin
      n_fail++; $display("FAIL mode_second_entry: avail,data=%b,%h expected 1,32", avail2, p_data2);
    end
    p_pop();
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge h_phi2);
      if (!full2) ok = 1'b1;
    end
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL mode_drain: h_full stuck at %b expected 0", full2);
    end
    h_multi = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_stream();
    int got_n;
    h_multi = 1'b1;
    apply_reset();
    sb_q.delete();
    pushes = 0; pops = 0; got_n = 0;
    fork
      begin : host_side
        for (int i = 0; i < 20; i++) begin
          bit sent;
          sent = 1'b0;
          for (int t = 0; t < 400 && !sent; t++) begin
            @(posedge h_phi2);
            if (pushes - pops == 4) begin
              n_checks++;
              if (full4 !== 1'b1) begin
                n_fail++; $display("FAIL stream_full_bound: h_full=%b expected 1 at 4 entries", full4);
              end
            end
            if ($urandom_range(0, 3) != 0 && !full4) begin
              h_data = 8'(i); h_sel = 1'b1; h_we_b = 1'b0;
              @(negedge h_phi2);
              sb_q.push_back(8'(i));
              pushes++;
              sent = 1'b1;
            end else begin
              h_sel = 1'b0; h_we_b = 1'b1;
            end
          end
          if (!sent) begin
            n_checks++; n_fail++;
            $display("FAIL stream_write_timeout: value %0d never accepted", i);
          end
        end
        @(posedge h_phi2);
        h_sel = 1'b0; h_we_b = 1'b1;
      end
      begin : parasite_side
        for (int t = 0; t < 3000 && got_n < 20; t++) begin
          logic [7:0] expv;
          @(negedge p_phi2);
          if (pushes == pops) begin
            n_checks++;
            if (avail4 !== 1'b0) begin
              n_fail++; $display("FAIL stream_empty_bound: avail=%b expected 0 when empty", avail4);
            end
          end
          p_en   = 1'($urandom_range(0, 1));
          p_sel  = ($urandom_range(0, 2) != 0);
          p_rdnw = ($urandom_range(0, 4) != 0);
          if (p_en && p_sel && p_rdnw && avail4) begin
            n_checks++;
            if (sb_q.size() == 0) begin
              n_fail++; $display("FAIL stream_phantom: data=%h available with model empty", p_data4);
            end else begin
              expv = sb_q.pop_front();
              if (p_data4 !== expv) begin
                n_fail++; $display("FAIL stream_data: got %h expected %h", p_data4, expv);
              end
            end
            got_n++;
            @(posedge p_phi2);
            pops++;
          end
        end
        p_sel = 1'b0; p_en = 1'b1; p_rdnw = 1'b1;
      end
    join
    n_checks++;
    if (got_n != 20 || pushes != 20 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_totals: read=%0d pushed=%0d left=%0d expected 20,20,0", got_n, pushes, sb_q.size());
    end
    n_checks++;
    if (ovr4 !== 1'b0) begin
      n_fail++; $display("FAIL stream_no_overrun: ovr=%b expected 0", ovr4);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    bit ok;
    apply_reset();
    h_multi = 1'b1;
    host_write(8'h01);
    host_write(8'h02);
    host_write(8'h03);
    wait_avail(4, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL midrst_prefill: avail=%b expected 1", avail4);
    end
    @(posedge h_phi2); #0.25;
    h_rst_b = 1'b0;
    #0.5;
    for (int d = 2; d <= 4; d += 2) begin
      n_checks++;
      if (outs_of(d) !== 11'h000) begin
        n_fail++; $display("FAIL midrst_async_dut%0d: outputs=%h expected 000", d, outs_of(d));
      end
    end
    #3;
    @(posedge h_phi2); #0.25;
    h_rst_b = 1'b1;
    host_write(8'h7E);
    wait_avail(4, ok);
    n_checks++;
    if (!ok || p_data4 !== 8'h7E) begin
      n_fail++; $display("FAIL midrst_first_value: seen=%b data=%h expected 1,7e", ok, p_data4);
    end
    p_pop();
    @(negedge p_phi2);
    n_checks++;
    if (avail4 !== 1'b0) begin
      n_fail++; $display("FAIL midrst_only_one: avail=%b expected 0", avail4);
    end
  endtask

`ifdef HP_FIFO_NMI_EN
  task automatic test_nmi();
    apply_reset();
    h_multi = 1'b1;
    repeat (6) @(negedge p_phi2);
    host_write(8'h41);
    repeat (6) @(negedge p_phi2);
    n_checks++;
    if (nmi2 !== 1'b0) begin
      n_fail++; $display("FAIL nmi_one_entry: p_nmi=%b expected 0", nmi2);
    end
    host_write(8'h42);
    repeat (6) @(negedge p_phi2);
    n_checks++;
    if (nmi2 !== 1'b1) begin
      n_fail++; $display("FAIL nmi_full: p_nmi=%b expected 1", nmi2);
    end
    p_pop();
    @(posedge p_phi2);
    @(negedge p_phi2);
    n_checks++;
    if (nmi2 !== 1'b0) begin
      n_fail++; $display("FAIL nmi_after_read: p_nmi=%b expected 0", nmi2);
    end
  endtask
`endif

  // ---------------------------------------------------------------------------
  initial begin
    #400000;
    $display("FAIL watchdog: still running at %0t, expected to have finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_multi();
    test_single();
    test_mode_change();
    test_stream();
    test_reset_mid();
`ifdef HP_FIFO_NMI_EN
    test_nmi();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
